// File: rtl/score_loader_pkg.sv
// Shared constants and FSM state type for the score loader.
// Imported by the loader top and its byte timer.
package score_loader_pkg;

   localparam logic [7:0]   START_BYTE      = 8'hA5;
   localparam logic [7:0]   END_BYTE        = 8'h5A;
   localparam int unsigned  TIMEOUT_DEFAULT = 50_000_000;

   typedef enum logic [2:0] {
      StIdle,
      StSlot,
      StHi,
      StLo,
      StTerm,
      StErr
   } state_e;

   function automatic logic state_busy(input state_e s);
      return s inside {StSlot, StHi, StLo, StTerm};
   endfunction

endpackage

// File: rtl/score_loader_byte_timer.sv
// Inter-byte watchdog: counts while running, saturates at TIMEOUT and flags it.
// A clear always wins over counting.
module score_loader_byte_timer
   import score_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_run,
   output logic o_timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_limit;

   assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT));
   assign o_timeout  = i_run && w_at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run && !w_at_limit) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/score_loader.sv
// Parses A5/slot/{HI,LO}*/5A frames from the UART byte stream and writes the
// resulting note words, plus a zero terminator, into the score register file.
module score_loader
   import score_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned SLOT_W  = 3,
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_byte,
   output logic              o_wen,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [15:0]       o_note_cnt
);

   localparam int unsigned IDX_W = ADDR_W - SLOT_W;

   state_e            r_state,    w_state_d;
   logic [SLOT_W-1:0] r_slot,     w_slot_d;
   logic [3:0]        r_hi,       w_hi_d;
   logic [IDX_W-1:0]  r_index,    w_index_d;
   logic [15:0]       r_note_cnt, w_note_cnt_d;
   logic              r_done,     w_done_d;
   logic              r_err,      w_err_d;
   logic              r_wen,      w_wen_d;
   logic [ADDR_W-1:0] r_waddr,    w_waddr_d;
   logic [DATA_W-1:0] r_wdata,    w_wdata_d;

   logic w_byte;
   logic w_run;
   logic w_timeout;

   assign w_byte = i_enable && i_rx_valid;
   assign w_run  = (r_state == StSlot) || (r_state == StHi) || (r_state == StLo);

   score_loader_byte_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (!i_enable || w_byte || !w_run),
      .i_run     (w_run),
      .o_timeout (w_timeout)
   );

   always_comb begin
      w_state_d    = r_state;
      w_slot_d     = r_slot;
      w_hi_d       = r_hi;
      w_index_d    = r_index;
      w_note_cnt_d = r_note_cnt;
      w_done_d     = r_done;
      w_err_d      = r_err;
      w_wen_d      = 1'b0;
      w_waddr_d    = r_waddr;
      w_wdata_d    = r_wdata;

      unique case (r_state)
         StIdle: begin
            if (w_byte && (i_rx_byte == START_BYTE)) begin
               w_state_d    = StSlot;
               w_done_d     = 1'b0;
               w_err_d      = 1'b0;
               w_note_cnt_d = '0;
               w_index_d    = '0;
            end
         end
         StSlot: begin
            if (w_byte) begin
               w_slot_d  = i_rx_byte[SLOT_W-1:0];
               w_state_d = StHi;
            end else if (w_timeout) begin
               w_state_d = StErr;
            end
         end
         StHi: begin
            if (w_byte) begin
               if (i_rx_byte == END_BYTE) begin
                  w_wen_d   = 1'b1;
                  w_waddr_d = {r_slot, r_index};
                  w_wdata_d = '0;
                  w_state_d = StTerm;
               end else if (i_rx_byte[7]) begin
                  w_state_d = StErr;
               end else begin
                  w_hi_d    = i_rx_byte[3:0];
                  w_state_d = StLo;
               end
            end else if (w_timeout) begin
               w_state_d = StErr;
            end
         end
         StLo: begin
            if (w_byte) begin
               // The last index is kept free for the terminator word.
               if (r_index == '1) begin
                  w_state_d = StErr;
               end else begin
                  w_wen_d      = 1'b1;
                  w_waddr_d    = {r_slot, r_index};
                  w_wdata_d    = DATA_W'({r_hi, i_rx_byte});
                  w_index_d    = r_index + IDX_W'(1);
                  w_note_cnt_d = r_note_cnt + 16'd1;
                  w_state_d    = StHi;
               end
            end else if (w_timeout) begin
               w_state_d = StErr;
            end
         end
         StTerm: begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
         end
         StErr: begin
            w_err_d   = 1'b1;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase

      if (!i_enable) begin
         w_state_d = StIdle;
         w_done_d  = r_done;
         w_err_d   = r_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_slot     <= '0;
         r_hi       <= '0;
         r_index    <= '0;
         r_note_cnt <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_wen      <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
      end else begin
         r_state    <= w_state_d;
         r_slot     <= w_slot_d;
         r_hi       <= w_hi_d;
         r_index    <= w_index_d;
         r_note_cnt <= w_note_cnt_d;
         r_done     <= w_done_d;
         r_err      <= w_err_d;
         r_wen      <= w_wen_d;
         r_waddr    <= w_waddr_d;
         r_wdata    <= w_wdata_d;
      end
   end

   // Gating by enable drops a write that is already queued when writing mode ends.
   assign o_wen      = r_wen && i_enable;
   assign o_waddr    = r_waddr;
   assign o_wdata    = r_wdata;
   assign o_busy     = state_busy(r_state);
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_note_cnt = r_note_cnt;

endmodule

// File: tb/tb_score_loader.sv
// Scoreboard bench: a frame-level parser predicts writes and status; a monitor
// compares every regfile write strobe against the predicted queue.
module tb_score_loader;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned SLOT_W  = 3;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned TIMEOUT = 40;
   localparam int unsigned IDX_W   = ADDR_W - SLOT_W;
   localparam int          IDX_MAX = (1 << IDX_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [15:0]       note_cnt;

   always #5 clk = ~clk;

   score_loader #(
      .ADDR_W  (ADDR_W),
      .SLOT_W  (SLOT_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (enable),
      .i_rx_valid (rx_valid),
      .i_rx_byte  (rx_byte),
      .o_wen      (wen),
      .o_waddr    (waddr),
      .o_wdata    (wdata),
      .o_busy     (busy),
      .o_done     (done),
      .o_err      (err),
      .o_note_cnt (note_cnt)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   bit  m_done = 0;
   bit  m_err = 0;
   int  m_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected none", waddr, wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(waddr), 32'(e.addr));
            check("wr_data", 32'(wdata), 32'(e.data));
         end
      end
   end

   // Frame-level reference: scan for START, take a slot byte, then HI/LO pairs until END.
   // A frame still open at stream end times out unless writing mode was dropped.
   task automatic model_stream(input logic [7:0] s[$], input bit abort_by_enable);
      int               pos = 0;
      int               idx = 0;
      bit               open = 0;
      logic [7:0]       b, h, l;
      logic [SLOT_W-1:0] slot = '0;
      wr_t              w;
      while (pos < s.size()) begin
         b = s[pos];
         pos++;
         if (b != 8'hA5) continue;
         m_done = 0; m_err = 0; m_cnt = 0; idx = 0; open = 1;
         if (pos >= s.size()) break;
         b = s[pos];
         pos++;
         slot = b[SLOT_W-1:0];
         while (1) begin
            if (pos >= s.size()) break;
            h = s[pos];
            pos++;
            if (h == 8'h5A) begin
               w.addr = {slot, IDX_W'(idx)};
               w.data = '0;
               exp_q.push_back(w);
               m_done = 1; open = 0;
               break;
            end
            if (h[7]) begin
               m_err = 1; open = 0;
               break;
            end
            if (pos >= s.size()) break;
            l = s[pos];
            pos++;
            if (idx == IDX_MAX) begin
               m_err = 1; open = 0;
               break;
            end
            w.addr = {slot, IDX_W'(idx)};
            w.data = {h[3:0], l};
            exp_q.push_back(w);
            idx++;
            m_cnt++;
         end
      end
      if (open && !abort_by_enable) m_err = 1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_valid = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
   endtask

   task automatic send_all(input logic [7:0] s[$]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic run_seq(input logic [7:0] s[$], input bit abort_by_enable);
      model_stream(s, abort_by_enable);
      send_all(s);
      if (abort_by_enable) begin
         @(posedge clk);
         #1 enable = 1'b0;
         repeat (3) @(posedge clk);
         #1 enable = 1'b1;
      end
      repeat (TIMEOUT + 8) @(posedge clk);
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'(m_done));
      check({tag, "_err"}, 32'(err), 32'(m_err));
      check({tag, "_note_cnt"}, 32'(note_cnt), 32'(m_cnt));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] s[$];
      logic [7:0] b;
      int         n;

      #12;
      check("rst_wen", 32'(wen), 0);
      check("rst_waddr", 32'(waddr), 0);
      check("rst_wdata", 32'(wdata), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_note_cnt", 32'(note_cnt), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 enable = 1'b1;

      s = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h04, 8'h56, 8'h5A};
      run_seq(s, 0);
      check_status("t1");
      check("t1_note_cnt_const", 32'(note_cnt), 2);
      check("t1_done_const", 32'(done), 1);

      s = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h5A};
      run_seq(s, 0);
      check_status("t2");
      check("t2_done_const", 32'(done), 1);

      s = '{8'hA5, 8'h01, 8'h0F, 8'hFF};
      model_stream(s, 0);
      send_all(s);
      @(negedge clk);
      check("t3_busy_mid", 32'(busy), 1);
      repeat (TIMEOUT + 8) @(posedge clk);
      check_status("t3");
      check("t3_err_const", 32'(err), 1);

      s = '{8'hA5, 8'h03, 8'h81};
      run_seq(s, 0);
      check_status("t4a");
      check("t4_err_const", 32'(err), 1);
      s = '{8'hA5, 8'h03, 8'h5A};
      run_seq(s, 0);
      check_status("t4b");
      check("t4_err_cleared", 32'(err), 0);

      s = '{8'hA5, 8'h01, 8'h02};
      run_seq(s, 1);
      check_status("t5a");
      s = '{8'h34};
      run_seq(s, 0);
      check_status("t5b");

      s = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44};
      run_seq(s, 0);
      check_status("t6");
      check("t6_note_cnt_const", 32'(note_cnt), 3);
      check("t6_err_const", 32'(err), 1);

      s = '{8'hA5, 8'h02, 8'h05};
      model_stream(s, 1);
      send_all(s);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_wen", 32'(wen), 0);
      check("arst_waddr", 32'(waddr), 0);
      check("arst_wdata", 32'(wdata), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      check("arst_err", 32'(err), 0);
      check("arst_note_cnt", 32'(note_cnt), 0);
      m_done = 0; m_err = 0; m_cnt = 0;
      #10 rst_n = 1'b1;

      for (int it = 0; it < 40; it++) begin
         s.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            s.push_back(b);
         end
         s.push_back(8'hA5);
         s.push_back(8'($urandom_range(0, 255)));
         n = int'($urandom_range(0, 4));
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 127));
            if (b == 8'h5A) b = 8'h1A;
            if ($urandom_range(0, 15) == 0) b = b | 8'h80;
            s.push_back(b);
            s.push_back(8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 4) != 0) s.push_back(8'h5A);
         run_seq(s, 0);
         check_status("rand");
      end

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
